// File: rtl/operand_accumulator.sv
// Sums a fixed number of unsigned operands over a valid/ready stream
// and presents the total until the downstream consumer takes it.
module adder_cascade #(
    parameter int width = 8
) (
    input  logic [width-1:0] a,
    input  logic [width-1:0] b,
    input  logic             carry_in,
    output logic [width-1:0] sum,
    output logic             carry_out
);
    logic [width:0] c;

    assign c[0] = carry_in;

    for (genvar i = 0; i < width; i++) begin : g_bit
        assign sum[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign carry_out = c[width];
endmodule

module operand_accumulator #(
    parameter int bits  = 8,
    parameter int count = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [bits-1:0]  in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [bits+$clog2(count)-1:0] out_sum
);
    localparam int ACC = bits + $clog2(count);
    localparam int CW  = $clog2(count + 1);

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DONE
    } state_t;

    state_t          state, state_d;
    logic [ACC-1:0]  acc, acc_d;
    logic [CW-1:0]   cnt, cnt_d;
    logic [ACC-1:0]  add_sum;
    logic [ACC-1:0]  data_ext;
    logic            carry_unused;

    assign data_ext = {{(ACC - bits){1'b0}}, in_data};

    adder_cascade #(
        .width(ACC)
    ) u_add (
        .a        (acc),
        .b        (data_ext),
        .carry_in (1'b0),
        .sum      (add_sum),
        .carry_out(carry_unused)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_d;
            acc   <= acc_d;
            cnt   <= cnt_d;
        end
    end

    // acc is zero in IDLE, so the adder output doubles as the first load
    always_comb begin
        state_d = state;
        acc_d   = acc;
        cnt_d   = cnt;
        if (flush) begin
            state_d = IDLE;
            acc_d   = '0;
            cnt_d   = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        acc_d   = add_sum;
                        cnt_d   = CW'(1);
                        state_d = ACCUM;
                    end
                end
                ACCUM: begin
                    if (in_valid) begin
                        acc_d = add_sum;
                        cnt_d = cnt + CW'(1);
                        if (cnt_d == CW'(count)) begin
                            state_d = DONE;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_d = IDLE;
                        acc_d   = '0;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    acc_d   = '0;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    assign in_ready  = (state != DONE);
    assign out_valid = (state == DONE);
    assign out_sum   = acc;
endmodule
